spi_leaf: RTL and testbench

SPI responder (mode 0, CPOL=0/CPHA=0) that is the far end of `spi_root`. It oversamples `cs`/`sclk`/`mosi` in the system clock domain and deserialises fixed-length MSB-first frames. In the same frames it shifts a word back on `miso` and raises a one-cycle trigger on a masked pattern match. It sits behind the SPI pins, alongside `spi_root` in the FPGA, and feeds received words and triggers to the system logic.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_in_sync.sv | 41 ++++
 rtl/spi_leaf.sv | 153 +++++++++++++++
 tb/tb_spi_leaf.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder.
// Imported by the synchroniser and the responder top.
package spi_pkg;

  localparam int SPI_DW = 16;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    DISARMED,
    IDLE,
    SHIFT
  } spi_leaf_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// One-bit pin synchroniser with history flop.
// Gives the synced level plus registered rise/fall pulses.
module spi_in_sync
  import spi_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int N = SPI_SYNC_STAGES;

  logic [N-1:0] sync_q;
  logic         hist_q;
  logic         rise_q;
  logic         fall_q;

  // Sync chain, history flop and registered edge detect
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], d};
      hist_q <= sync_q[N-1];
      rise_q <= sync_q[N-1] & ~hist_q;
      fall_q <= ~sync_q[N-1] & hist_q;
    end
  end

  // Level is taken from the history flop so it lines up with the pulses
  assign level = hist_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_leaf.sv
// SPI mode-0 responder oversampled in the clk domain.
// Deserialises fixed frames, returns tx_data, flags matches.
module spi_leaf
  import spi_pkg::*;
#(
  parameter int DW    = SPI_DW,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [DW-1:0]    tx_data,
  input  logic [DW-1:0]    trg_word,
  input  logic [DW-1:0]    trg_mask,
  output logic [DW-1:0]    rx_data,
  output logic             rx_valid,
  output logic             trg,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  localparam int CW = $clog2(DW + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DW);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DW + 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic sync_unused;

  spi_in_sync u_cs (
    .clk   (clk),
    .rstn  (rstn),
    .d     (cs),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_in_sync u_sclk (
    .clk   (clk),
    .rstn  (rstn),
    .d     (sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_in_sync u_mosi (
    .clk   (clk),
    .rstn  (rstn),
    .d     (mosi),
    .level (mosi_lvl),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  assign sync_unused = ^{sclk_lvl, sclk_fall,
                         mosi_rise, mosi_fall};

  spi_leaf_state_t  state_q, state_d;
  logic [DW-1:0]    tx_q, tx_d;
  logic [DW-1:0]    sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    rx_q, rx_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             vld_q, vld_d;
  logic             trg_q, trg_d;
  logic             err_q, err_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DISARMED;
      tx_q    <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      rx_q    <= '0;
      fcnt_q  <= '0;
      vld_q   <= 1'b0;
      trg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      fcnt_q  <= fcnt_d;
      vld_q   <= vld_d;
      trg_q   <= trg_d;
      err_q   <= err_d;
    end
  end

  // Next state; an sclk edge is folded in before a same-cycle cs rise
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    fcnt_d  = fcnt_q;
    vld_d   = 1'b0;
    trg_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      DISARMED: begin
        if (cs_lvl) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          tx_d    = tx_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          sr_d = {sr_q[DW-2:0], mosi_lvl};
          tx_d = {tx_q[DW-2:0], 1'b0};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
        if (cs_rise) begin
          state_d = IDLE;
          tx_d    = '0;
          if (cnt_d == CNT_FULL) begin
            rx_d   = sr_d;
            vld_d  = 1'b1;
            fcnt_d = fcnt_q + 1'b1;
            trg_d  = ((sr_d ^ trg_word) & trg_mask) == '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = DISARMED;
    endcase
  end

  assign busy      = state_q == SHIFT;
  assign miso      = busy & tx_q[DW-1];
  assign rx_data   = rx_q;
  assign rx_valid  = vld_q;
  assign trg       = trg_q;
  assign frame_err = err_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_spi_leaf.sv
// Bench for spi_leaf: a root model drives frames,
// a scoreboard checks every rx_valid/frame_err pulse.
module tb_spi_leaf;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cs = 1'b1;
  logic          sclk = 1'b0;
  logic          mosi = 1'b0;
  logic          miso;
  logic [DW-1:0] tx_data = '0;
  logic [DW-1:0] trg_word = '0;
  logic [DW-1:0] trg_mask = '0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          trg;
  logic          frame_err;
  logic [CW-1:0] frame_cnt;
  logic          busy;

  spi_leaf #(.DW(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cs        (cs),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .tx_data   (tx_data),
    .trg_word  (trg_word),
    .trg_mask  (trg_mask),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .trg       (trg),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          kind;
    logic [DW-1:0] rx;
    logic          trg;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic [DW-1:0] word;
    logic [DW-1:0] tx;
    logic [DW-1:0] tw;
    logic [DW-1:0] tm;
    logic          etrg;
  } vec_t;

  exp_t          sb[$];
  vec_t          tbl[6];
  logic [DW-1:0] exp_rx = '0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: every output pulse must match the next expectation
  always @(negedge clk) begin
    if (rstn && (rx_valid || frame_err || trg)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, rx_valid, frame_err, trg}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, rx_valid, frame_err},
            e.kind ? 32'd1 : 32'd2);
        chk("rx_data", {16'd0, rx_data}, {16'd0, e.rx});
        chk("trg", {31'd0, trg}, {31'd0, e.trg});
        chk("frame_cnt", {28'd0, frame_cnt}, {28'd0, e.cnt});
      end
    end
  end

  task automatic expect_ok(input logic [DW-1:0] w, input logic t);
    exp_cnt = exp_cnt + 4'd1;
    exp_rx  = w;
    sb.push_back('{kind: 1'b0, rx: w, trg: t, cnt: exp_cnt});
  endtask

  task automatic expect_err();
    sb.push_back('{kind: 1'b1, rx: exp_rx, trg: 1'b0, cnt: exp_cnt});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    cyc(1);
    cs = 1'b0;
    cyc(6);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
  endtask

  task automatic bit_xfer(input logic b, output logic m);
    mosi = b;
    cyc(3);
    sclk = 1'b1;
    m = miso;
    cyc(3);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n,
                           output logic [31:0] got);
    logic m;
    got = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bit_xfer(w[i], m);
      got = {got[30:0], m};
    end
  endtask

  // cs rise, then check the pulse lands exactly 4 clk later
  task automatic frame_end(input logic pulse);
    cyc(3);
    cs = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("no_pulse_at_3", {31'd0, rx_valid | frame_err}, 32'd0);
    @(negedge clk);
    chk("pulse_at_4", {31'd0, rx_valid | frame_err}, {31'd0, pulse});
    cyc(14);
  endtask

  task automatic full_frame(input logic [DW-1:0] w,
                            input logic [DW-1:0] tx);
    logic [31:0] got;
    tx_data = tx;
    frame_start();
    send_bits({16'd0, w}, DW, got);
    chk("miso_word", got, {16'd0, tx});
    frame_end(1'b1);
  endtask

  initial begin
    logic [31:0] got;
    tbl[0] = '{16'hA5C3, 16'h3C5A, 16'h8000, 16'hF000, 1'b0};
    tbl[1] = '{16'h8ABC, 16'h1111, 16'h8000, 16'hF000, 1'b1};
    tbl[2] = '{16'h9ABC, 16'h2222, 16'h8000, 16'hF000, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    tbl[4] = '{16'h0000, 16'hFFFF, 16'h00FF, 16'h00FF, 1'b0};
    tbl[5] = '{16'h12FF, 16'h8001, 16'h00FF, 16'h00FF, 1'b1};

    cyc(5);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_trg", {31'd0, trg}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rx_data", {16'd0, rx_data}, 32'd0);
    chk("rst_frame_cnt", {28'd0, frame_cnt}, 32'd0);
    rstn = 1'b1;
    cyc(10);

    tx_data = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      sclk = 1'b1;
      cyc(4);
      chk("idle_miso", {31'd0, miso}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      sclk = 1'b0;
      cyc(4);
    end
    cyc(10);

    trg_word = 16'h8000;
    trg_mask = 16'hF000;
    expect_ok(16'hA5C3, 1'b0);
    full_frame(16'hA5C3, 16'h3C5A);
    chk("nom_busy_after", {31'd0, busy}, 32'd0);
    chk("nom_miso_after", {31'd0, miso}, 32'd0);
    chk("nom_cnt", {28'd0, frame_cnt}, 32'd1);

    expect_ok(16'h8ABC, 1'b1);
    full_frame(16'h8ABC, 16'h0F0F);
    expect_ok(16'h9ABC, 1'b0);
    full_frame(16'h9ABC, 16'hF0F0);

    expect_err();
    frame_start();
    send_bits(32'h0000_00FF, 8, got);
    frame_end(1'b1);
    chk("short_rx_held", {16'd0, rx_data}, 32'h0000_9ABC);
    chk("short_cnt_held", {28'd0, frame_cnt}, 32'd3);

    expect_err();
    frame_start();
    send_bits(32'h0001_8ABC, 17, got);
    frame_end(1'b1);

    frame_start();
    send_bits(32'h0000_0055, 7, got);
    rstn = 1'b0;
    exp_cnt = '0;
    exp_rx  = '0;
    cyc(3);
    rstn = 1'b1;
    send_bits(32'h0000_01AB, 9, got);
    frame_end(1'b0);
    chk("mid_rst_rx", {16'd0, rx_data}, 32'd0);
    chk("mid_rst_cnt", {28'd0, frame_cnt}, 32'd0);

    expect_ok(16'h1234, 1'b0);
    full_frame(16'h1234, 16'hBEEF);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        trg_word = tbl[i].tw;
        trg_mask = tbl[i].tm;
        expect_ok(tbl[i].word, tbl[i].etrg);
        full_frame(tbl[i].word, tbl[i].tx);
      end
    end
    chk("wrap_cnt", {28'd0, frame_cnt}, 32'd3);

    cyc(10);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
